// File: rtl/ptp_bridge_pkg.sv
// Shared constants and types for the PTP bridge RX debug counter block.
//   RX_DBG_CNT_START_ADDR : default first AVMM word address of the RX debug window
//   RX_DBG_ID_SIG         : low 16 bits of the ID register ("RD")
//   RX_DBG_OFF_*          : register offsets within the window
//   ctrl_reg_t            : CTRL register layout, {freeze, clr}; clr sits in bit 0
//   rx_dbg_num_cntr()     : number of counters for a given channel count / error option
package ptp_bridge_pkg;

  localparam int unsigned RX_DBG_CNT_START_ADDR = 'h40;
  localparam logic [15:0] RX_DBG_ID_SIG         = 16'h5244;

  localparam int unsigned RX_DBG_OFF_CTRL       = 'h00;
  localparam int unsigned RX_DBG_OFF_HSSI2EGR   = 'h01;
  localparam int unsigned RX_DBG_OFF_ID         = 'h1F;

  typedef struct packed {
    logic freeze;
    logic clr;
  } ctrl_reg_t;

  // One HSSI tap, N+1 egress-parse taps, N demux taps, plus the optional error counter.
  function automatic int unsigned rx_dbg_num_cntr(input int unsigned num_chnl, input bit err_en);
    return 2 * num_chnl + 2 + (err_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/ptp_bridge_rx_dbg_sat_cntr.sv
// Bank of NUM_CNTR saturating counters.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   inc_en_i       : global increment enable (low while frozen)
//   inc_i          : per-counter increment request
//   clr_i          : zero every counter
//   load_i         : per-counter preset strobe
//   load_data_i    : preset data, merged under load_be_i byte lanes
//   cnt_o          : counter values
// Per counter, clear beats preset and preset beats increment.
module ptp_bridge_rx_dbg_sat_cntr #(
  parameter int unsigned NUM_CNTR   = 8,
  parameter int unsigned CNTR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 inc_en_i,
  input  logic [NUM_CNTR-1:0]                  inc_i,
  input  logic                                 clr_i,
  input  logic [NUM_CNTR-1:0]                  load_i,
  input  logic [DATA_WIDTH-1:0]                load_data_i,
  input  logic [DATA_WIDTH/8-1:0]              load_be_i,
  output logic [NUM_CNTR-1:0][CNTR_WIDTH-1:0]  cnt_o
);

  localparam logic [CNTR_WIDTH-1:0] CntMax = '1;
  localparam logic [CNTR_WIDTH-1:0] CntOne = CNTR_WIDTH'(1);

  logic [NUM_CNTR-1:0][CNTR_WIDTH-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_CNTR; i++) begin
      if (clr_i) begin
        cnt_d[i] = '0;
      end else if (load_i[i]) begin
        for (int b = 0; b < CNTR_WIDTH; b++) begin
          if (load_be_i[b/8]) cnt_d[i][b] = load_data_i[b];
        end
      end else if (inc_en_i && inc_i[i] && (cnt_q[i] != CntMax)) begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ptp_bridge_rx_dbg_cntr_blk.sv
// Per-pipeline RX debug packet counters with an AVMM slave.
// Counts tlast handshakes at three RX taps (HSSI->egress parse, egress parse->demux,
// demux->DMA channel) and exposes them plus CTRL and ID in a MAX_ADDR-word window at BASE_ADDR.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   avmm_*                       : word-addressed slave, fixed 2-cycle read latency
//   hssi2egr_tvalid/tready/tlast : HSSI RX into egress parser; hssi2egr_terr with tlast
//   egr2edmx_*                   : bit 0 user port, bits 1..N DMA channels
//   edmx2dma_*                   : demux output to DMA channel n
// Build option: define PTP_BRIDGE_RX_DBG_ERR_CNT_EN to add an errored-packet counter just
// after the last demux counter; otherwise hssi2egr_terr is ignored and that offset reads 0.
module ptp_bridge_rx_dbg_cntr_blk
  import ptp_bridge_pkg::*;
#(
  parameter int unsigned DMA_CHNL_PER_PIPE = 3,
  parameter int unsigned CNTR_WIDTH        = 32,
  parameter int unsigned ADDR_WIDTH        = 8,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned INST_ID           = 0,
  parameter int unsigned BASE_ADDR         = RX_DBG_CNT_START_ADDR,
  parameter int unsigned MAX_ADDR          = 'h20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        avmm_address,
  input  logic                         avmm_write,
  input  logic [DATA_WIDTH-1:0]        avmm_writedata,
  input  logic [DATA_WIDTH/8-1:0]      avmm_byteenable,
  input  logic                         avmm_read,
  output logic [DATA_WIDTH-1:0]        avmm_readdata,
  output logic                         avmm_readdatavalid,
  input  logic                         hssi2egr_tvalid,
  input  logic                         hssi2egr_tready,
  input  logic                         hssi2egr_tlast,
  input  logic                         hssi2egr_terr,
  input  logic [DMA_CHNL_PER_PIPE:0]   egr2edmx_tvalid,
  input  logic [DMA_CHNL_PER_PIPE:0]   egr2edmx_tready,
  input  logic [DMA_CHNL_PER_PIPE:0]   egr2edmx_tlast,
  input  logic [DMA_CHNL_PER_PIPE-1:0] edmx2dma_tvalid,
  input  logic [DMA_CHNL_PER_PIPE-1:0] edmx2dma_tready,
  input  logic [DMA_CHNL_PER_PIPE-1:0] edmx2dma_tlast
);

  localparam int unsigned N = DMA_CHNL_PER_PIPE;

`ifdef PTP_BRIDGE_RX_DBG_ERR_CNT_EN
  localparam bit ErrCntEn = 1'b1;
`else
  localparam bit ErrCntEn = 1'b0;
`endif

  localparam int unsigned NumCntr = rx_dbg_num_cntr(N, ErrCntEn);

  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   WinSize  = (ADDR_WIDTH+1)'(MAX_ADDR);
  localparam logic [31:0]           IdWord   = {8'(INST_ID), 8'(DMA_CHNL_PER_PIPE), RX_DBG_ID_SIG};

  // Counter index i lives at offset RX_DBG_OFF_HSSI2EGR + i.
  logic [NumCntr-1:0] evt_d, evt_q;

  always_comb begin
    evt_d = '0;
    evt_d[0] = hssi2egr_tvalid & hssi2egr_tready & hssi2egr_tlast;
    evt_d[N+1:1] = egr2edmx_tvalid & egr2edmx_tready & egr2edmx_tlast;
    evt_d[2*N+1:N+2] = edmx2dma_tvalid & edmx2dma_tready & edmx2dma_tlast;
`ifdef PTP_BRIDGE_RX_DBG_ERR_CNT_EN
    evt_d[2*N+2] = hssi2egr_tvalid & hssi2egr_tready & hssi2egr_tlast & hssi2egr_terr;
`endif
  end

`ifndef PTP_BRIDGE_RX_DBG_ERR_CNT_EN
  logic unused_terr;
  assign unused_terr = hssi2egr_terr;
`endif

  // Address decode; addresses outside the window belong to another slave.
  logic [ADDR_WIDTH-1:0] off;
  logic                  in_win, wr_hit, rd_hit, ctrl_wr;

  assign off     = avmm_address - BaseAddr;
  assign in_win  = (avmm_address >= BaseAddr) && ({1'b0, off} < WinSize);
  assign wr_hit  = avmm_write & in_win;
  assign rd_hit  = avmm_read & in_win;
  assign ctrl_wr = wr_hit && (off == ADDR_WIDTH'(RX_DBG_OFF_CTRL)) && avmm_byteenable[0];

  ctrl_reg_t ctrl_d, ctrl_q;

  always_comb begin
    ctrl_d     = ctrl_q;
    ctrl_d.clr = 1'b0;
    if (ctrl_wr) begin
      ctrl_d.clr    = avmm_writedata[0];
      ctrl_d.freeze = avmm_writedata[1];
    end
  end

  logic [NumCntr-1:0]                 cnt_load;
  logic [NumCntr-1:0][CNTR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0]              rd_mux;

  always_comb begin
    cnt_load = '0;
    rd_mux   = '0;
    for (int i = 0; i < NumCntr; i++) begin
      if (off == ADDR_WIDTH'(RX_DBG_OFF_HSSI2EGR + i)) begin
        cnt_load[i] = wr_hit;
        rd_mux      = DATA_WIDTH'(cnt[i]);
      end
    end
    if (off == ADDR_WIDTH'(RX_DBG_OFF_CTRL)) rd_mux = {{(DATA_WIDTH-2){1'b0}}, ctrl_q};
    if (off == ADDR_WIDTH'(RX_DBG_OFF_ID))   rd_mux = DATA_WIDTH'(IdWord);
  end

  ptp_bridge_rx_dbg_sat_cntr #(
    .NUM_CNTR   (NumCntr),
    .CNTR_WIDTH (CNTR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sat_cntr (
    .clk_i       (clk),
    .rst_i       (rst),
    .inc_en_i    (~ctrl_q.freeze),
    .inc_i       (evt_q),
    .clr_i       (ctrl_q.clr),
    .load_i      (cnt_load),
    .load_data_i (avmm_writedata),
    .load_be_i   (avmm_byteenable),
    .cnt_o       (cnt)
  );

  // Two-stage read pipe: capture pre-update contents, then present one cycle later.
  logic                  rd_vld_q, rsp_vld_q;
  logic [DATA_WIDTH-1:0] rd_data_q, rsp_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_q      <= '0;
      ctrl_q     <= '0;
      rd_vld_q   <= 1'b0;
      rd_data_q  <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      evt_q      <= evt_d;
      ctrl_q     <= ctrl_d;
      rd_vld_q   <= rd_hit;
      rd_data_q  <= rd_mux;
      rsp_vld_q  <= rd_vld_q;
      rsp_data_q <= rd_data_q;
    end
  end

  assign avmm_readdata      = rsp_data_q;
  assign avmm_readdatavalid = rsp_vld_q;

endmodule

// File: tb/tb_ptp_bridge_rx_dbg_cntr_blk.sv
module tb_ptp_bridge_rx_dbg_cntr_blk;
  import ptp_bridge_pkg::*;

  localparam int N    = 3;
  localparam int INST = 1;
  localparam int BASE = RX_DBG_CNT_START_ADDR;
`ifdef PTP_BRIDGE_RX_DBG_ERR_CNT_EN
  localparam int          NC      = 2 * N + 3;
  localparam logic [31:0] ERR_EXP = 32'd3;
`else
  localparam int          NC      = 2 * N + 2;
  localparam logic [31:0] ERR_EXP = 32'd0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   avmm_address = '0;
  logic         avmm_write = 1'b0;
  logic [31:0]  avmm_writedata = '0;
  logic [3:0]   avmm_byteenable = '0;
  logic         avmm_read = 1'b0;
  logic [31:0]  avmm_readdata;
  logic         avmm_readdatavalid;
  logic         hv = 1'b0, hr = 1'b0, hl = 1'b0, herr = 1'b0;
  logic [N:0]   ev = '0, er = '0, el = '0;
  logic [N-1:0] dv = '0, dr = '0, dl = '0;

  ptp_bridge_rx_dbg_cntr_blk #(
    .DMA_CHNL_PER_PIPE (N),
    .CNTR_WIDTH        (32),
    .ADDR_WIDTH        (8),
    .DATA_WIDTH        (32),
    .INST_ID           (INST),
    .BASE_ADDR         (BASE),
    .MAX_ADDR          ('h20)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .avmm_address       (avmm_address),
    .avmm_write         (avmm_write),
    .avmm_writedata     (avmm_writedata),
    .avmm_byteenable    (avmm_byteenable),
    .avmm_read          (avmm_read),
    .avmm_readdata      (avmm_readdata),
    .avmm_readdatavalid (avmm_readdatavalid),
    .hssi2egr_tvalid    (hv),
    .hssi2egr_tready    (hr),
    .hssi2egr_tlast     (hl),
    .hssi2egr_terr      (herr),
    .egr2edmx_tvalid    (ev),
    .egr2edmx_tready    (er),
    .egr2edmx_tlast     (el),
    .edmx2dma_tvalid    (dv),
    .edmx2dma_tready    (dr),
    .edmx2dma_tlast     (dl)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Counters are indexed by offset-1. A packet handshake seen in cycle k is counted in
  // cycle k+1 unless that cycle is frozen, cleared or presets the same counter.
  typedef struct { int due; logic [31:0] data; } rsp_t;
  rsp_t        exp_q[$];
  logic [31:0] m_cnt [NC];
  logic [NC-1:0] m_seen;
  bit          m_freeze, m_clr;
  int          cyc = 0;

  function automatic logic [NC-1:0] taps();
    logic [NC-1:0] e;
    e = '0;
    e[0] = hv & hr & hl;
    for (int k = 0; k <= N; k++) e[1+k] = ev[k] & er[k] & el[k];
    for (int k = 0; k < N; k++) e[N+2+k] = dv[k] & dr[k] & dl[k];
`ifdef PTP_BRIDGE_RX_DBG_ERR_CNT_EN
    e[2*N+2] = hv & hr & hl & herr;
`endif
    return e;
  endfunction

  function automatic logic [31:0] model_read(input int o);
    if (o == 0) return {30'd0, m_freeze, m_clr};
    if (o == 'h1F) return {8'(INST), 8'(N), 16'h5244};
    if (o >= 1 && o <= NC) return m_cnt[o-1];
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    int  o;
    bit  inwin;
    logic [NC-1:0] now;
    cyc++;
    if (rst) begin
      for (int i = 0; i < NC; i++) m_cnt[i] = '0;
      m_freeze = 0;
      m_clr    = 0;
      m_seen   = '0;
      exp_q.delete();
    end else begin
      o     = int'(avmm_address) - BASE;
      inwin = (o >= 0) && (o < 'h20);
      now   = taps();
      if (avmm_read && inwin) exp_q.push_back('{due: cyc + 1, data: model_read(o)});
      for (int i = 0; i < NC; i++) begin
        if (m_clr) m_cnt[i] = '0;
        else if (avmm_write && inwin && o == i + 1) begin
          for (int b = 0; b < 4; b++)
            if (avmm_byteenable[b]) m_cnt[i][8*b +: 8] = avmm_writedata[8*b +: 8];
        end else if (m_seen[i] && !m_freeze && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] += 1;
      end
      m_clr = 0;
      if (avmm_write && inwin && o == 0 && avmm_byteenable[0]) begin
        m_clr    = avmm_writedata[0];
        m_freeze = avmm_writedata[1];
      end
      m_seen = now;
    end
  end

  // Compare process: every cycle out of reset, response strobe and data against the model.
  always @(negedge clk) begin
    bit exp_v;
    if (!rst) begin
      exp_v = (exp_q.size() != 0) && (exp_q[0].due == cyc);
      chk("rdvalid", {31'd0, avmm_readdatavalid}, {31'd0, exp_v});
      if (exp_v) begin
        chk("rddata", avmm_readdata, exp_q[0].data);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int addr, input logic [31:0] d, input logic [3:0] be);
    avmm_address    = 8'(addr);
    avmm_write      = 1'b1;
    avmm_writedata  = d;
    avmm_byteenable = be;
    @(negedge clk);
    avmm_write      = 1'b0;
    avmm_byteenable = '0;
  endtask

  // Read with a hand-computed expectation and exact latency check.
  task automatic rd_lit(input int o, input logic [31:0] exp, input string name);
    avmm_address = 8'(BASE + o);
    avmm_read    = 1'b1;
    @(negedge clk);
    avmm_read = 1'b0;
    chk({name, "_early"}, {31'd0, avmm_readdatavalid}, 32'd0);
    @(negedge clk);
    chk({name, "_vld"}, {31'd0, avmm_readdatavalid}, 32'd1);
    chk(name, avmm_readdata, exp);
  endtask

  task automatic clr_taps();
    hv = 0; hr = 0; hl = 0; herr = 0;
    ev = '0; er = '0; el = '0;
    dv = '0; dr = '0; dl = '0;
  endtask

  initial begin
    logic [4:0] rdy_pat;
    logic [6:0] err_pat;
    int r;

    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset values and ID.
    rd_lit('h01, 32'd0, "reset_hssi");
    rd_lit('h1F, 32'h0103_5244, "id");

    // edmx2dma[2]: five tlast beats, one without tready.
    rdy_pat = 5'b11011;
    for (int k = 0; k < 5; k++) begin
      dv[2] = 1; dl[2] = 1; dr[2] = rdy_pat[k];
      @(negedge clk);
    end
    clr_taps();
    idle(3);
    rd_lit('h08, 32'd4, "edmx2");
    for (int o = 0; o < 10; o++) if (o != 8) rd_lit(o, 32'd0, $sformatf("zero_%0d", o));

    // Saturation.
    wr(BASE + 1, 32'hFFFF_FFFE, 4'hF);
    for (int k = 0; k < 3; k++) begin
      hv = 1; hr = 1; hl = 1;
      @(negedge clk);
    end
    clr_taps();
    idle(3);
    rd_lit('h01, 32'hFFFF_FFFF, "sat");

    // CLR in the same cycle as an egr2edmx[0] event.
    ev[0] = 1; er[0] = 1; el[0] = 1;
    wr(BASE + 0, 32'h1, 4'h1);
    clr_taps();
    idle(3);
    rd_lit('h02, 32'd0, "clr_egr0");
    rd_lit('h00, 32'd0, "clr_ctrl");
    rd_lit('h01, 32'd0, "clr_hssi");
    rd_lit('h08, 32'd0, "clr_edmx2");

    // Partial byte-lane preset.
    wr(BASE + 6, 32'hAABB_CCDD, 4'b0101);
    idle(1);
    rd_lit('h06, 32'h00BB_00DD, "preset_be");

    // FREEZE drops events; counting resumes after release.
    wr(BASE + 0, 32'h2, 4'h1);
    rd_lit('h00, 32'd2, "freeze_ctrl");
    for (int k = 0; k < 10; k++) begin
      ev[1] = 1; er[1] = 1; el[1] = 1;
      @(negedge clk);
    end
    clr_taps();
    idle(2);
    wr(BASE + 0, 32'h0, 4'h1);
    for (int k = 0; k < 2; k++) begin
      ev[1] = 1; er[1] = 1; el[1] = 1;
      @(negedge clk);
    end
    clr_taps();
    idle(3);
    rd_lit('h03, 32'd2, "freeze");

    // Out-of-window read and write.
    avmm_address = 8'(BASE + 'h20);
    avmm_read    = 1'b1;
    @(negedge clk);
    avmm_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("oow_vld", {31'd0, avmm_readdatavalid}, 32'd0);
      @(negedge clk);
    end
    wr(BASE + 'h21, 32'h1, 4'hF);
    wr(BASE - 1, 32'h1, 4'hF);
    idle(2);

    // Error packets.
    err_pat = 7'b0101001;
    for (int k = 0; k < 7; k++) begin
      hv = 1; hr = 1; hl = 1; herr = err_pat[k];
      @(negedge clk);
    end
    clr_taps();
    idle(3);
    rd_lit(2 * N + 3, ERR_EXP, "errcnt");
    rd_lit('h01, 32'd7, "hssi7");
    rd_lit('h03, 32'd2, "oow_nochange");

    // Reset with a read in flight.
    avmm_address = 8'(BASE + 1);
    avmm_read    = 1'b1;
    @(negedge clk);
    avmm_read = 1'b0;
    rst       = 1'b1;
    idle(2);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_midread_vld", {31'd0, avmm_readdatavalid}, 32'd0);
      @(negedge clk);
    end
    rd_lit('h01, 32'd0, "rst_hssi");

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      hv = 1'($urandom); hr = 1'($urandom); hl = 1'($urandom); herr = 1'($urandom);
      ev = (N+1)'($urandom); er = (N+1)'($urandom); el = (N+1)'($urandom);
      dv = N'($urandom); dr = N'($urandom); dl = N'($urandom);
      avmm_read  = 1'b0;
      avmm_write = 1'b0;
      avmm_byteenable = '0;
      r = $urandom_range(0, 11);
      if (r <= 3) begin
        avmm_read    = 1'b1;
        avmm_address = 8'(BASE + $urandom_range(0, 'h1F));
      end else if (r == 4) begin
        avmm_read    = 1'b1;
        avmm_address = ($urandom_range(0, 1) != 0) ? 8'(BASE + $urandom_range('h20, 'h3F))
                                                   : 8'($urandom_range(0, BASE - 1));
      end else if (r == 5) begin
        avmm_write      = 1'b1;
        avmm_address    = 8'(BASE);
        avmm_writedata  = {$urandom_range(0, 3) == 0 ? 1'b1 : 1'b0,
                           ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0};
        avmm_writedata  = 32'(avmm_writedata[1:0]) | ($urandom() & 32'hFFFF_FFFC);
        avmm_byteenable = 4'($urandom);
      end else if (r == 6) begin
        avmm_write      = 1'b1;
        avmm_address    = 8'(BASE + $urandom_range(1, NC + 1));
        avmm_writedata  = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                                      : $urandom();
        avmm_byteenable = 4'($urandom);
      end else if (r == 7) begin
        avmm_write      = 1'b1;
        avmm_address    = 8'(BASE + $urandom_range('h20, 'h3F));
        avmm_writedata  = $urandom();
        avmm_byteenable = 4'hF;
      end
      @(negedge clk);
    end
    avmm_read  = 1'b0;
    avmm_write = 1'b0;
    clr_taps();
    idle(5);
    if (exp_q.size() != 0) chk("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ptp_bridge_rx_dbg_cntr_blk.md
Name: ptp_bridge_rx_dbg_cntr_blk

Overview:
- Per-pipeline RX-direction debug packet counters, the receive-side counterpart of the TX debug counters.
- Counts end-of-packet transfers at three RX taps: HSSI into egress parse, egress parse into demux (user plus DMA channels), and demux out to each DMA channel.
- Exposes the counts and a control register on an AVMM slave; one instance per pipeline.

Parameters:
- DMA_CHNL_PER_PIPE, 3, DMA channels served by this pipeline.
- CNTR_WIDTH, 32, counter width; must be <= DATA_WIDTH.
- ADDR_WIDTH, 8, AVMM word-address width.
- DATA_WIDTH, 32, AVMM data width.
- INST_ID, 0, pipeline index; readable from the ID register.
- BASE_ADDR, RX_DBG_CNT_START_ADDR, first word address owned by this instance.
- MAX_ADDR, 'h20, size of the owned window in words.

Ports:
- clk  in  1  block clock.
- rst  in  1  asynchronous, active-high reset.
- avmm_address  in  ADDR_WIDTH  word address.
- avmm_write  in  1  write strobe.
- avmm_writedata  in  DATA_WIDTH  write data.
- avmm_byteenable  in  DATA_WIDTH/8  byte lanes.
- avmm_read  in  1  read strobe.
- avmm_readdata  out  DATA_WIDTH  read data.
- avmm_readdatavalid  out  1  read response strobe.
- hssi2egr_tvalid/tready/tlast  in  1 each  HSSI RX into egress parser.
- hssi2egr_terr  in  1  packet error flag, qualified with tlast.
- egr2edmx_tvalid/tready/tlast  in  DMA_CHNL_PER_PIPE+1 each  bit0 = user port, bits 1..N = DMA channels.
- edmx2dma_tvalid/tready/tlast  in  DMA_CHNL_PER_PIPE each  demux output to DMA channel n.

Behaviour:
- Reset: all counters, CTRL, avmm_readdata and avmm_readdatavalid go to 0 asynchronously.
- Count events:
  - Event per bit = tvalid & tready & tlast, registered once (1-cycle enable pipeline).
  - The counter updates on the cycle after the enable register, so a counter reflects a handshake 2 clocks later.
- Counter rules:
  - +1 per event; saturates at all-ones, no wrap.
  - Counter value is zero-extended to DATA_WIDTH on read.
- Register map (offset = avmm_address - BASE_ADDR):
  - 0x00 CTRL: bit0 CLR, write-1 self-clearing pulse that zeroes all counters the next cycle; bit1 FREEZE, R/W, blocks increments while 1. Other bits read 0.
  - 0x01 hssi2egr count.
  - 0x02..0x02+N egr2edmx counts, user port first.
  - 0x03+N..0x02+2N edmx2dma counts, channel 0 first.
  - 0x1F ID: {INST_ID[7:0], DMA_CHNL_PER_PIPE[7:0], 16'h5244}.
  - Any other in-window offset reads 0; writes to it are ignored.
- Writes to counter offsets preset the counter under byteenable.
- Precedence on one counter in the same cycle: CLR > AVMM preset > increment.
- Reads:
  - Fixed 2-cycle latency: read sampled at edge T, readdatavalid high for exactly one cycle at T+2.
  - Returned value is the register contents at edge T (pre-increment).
  - Back-to-back reads are pipelined, one response per request, in order.
- Out-of-window addresses produce no readdatavalid and no state change; another slave owns them.
- Simultaneous read and write are not supported by the master; if both assert, the write executes and the read still responds.
- FREEZE=1: events arriving are dropped, not queued. On FREEZE 1->0, counting resumes the next cycle.
- Reset mid-read: the pending response is discarded; no readdatavalid after rst deasserts.

Optional Feature:
- Macro PTP_BRIDGE_RX_DBG_ERR_CNT_EN.
- Defined: adds an error counter at offset 0x02+2N+1 counting hssi2egr_tvalid & tready & tlast & terr, with the same pipeline, saturation, CLR and FREEZE rules as the other counters.
- Undefined: hssi2egr_terr is ignored and that offset reads 0.

Decomposition:
- ptp_bridge_pkg gets RX_DBG_CNT_START_ADDR, RX_DBG_ID_SIG = 16'h5244, register offset localparams, and a ctrl_reg_t packed struct {FREEZE, CLR}.
- One sub-module, ptp_bridge_rx_dbg_sat_cntr: NUM_CNTR saturating counters with enable, clear, per-counter load and byteenable.

Test Plan:
- Reset, read 0x01 -> 0 with readdatavalid exactly at T+2; read 0x1F with INST_ID=1, N=3 -> 0x0103_5244.
- 5 tlast handshakes on edmx2dma[2] (one with tready=0, not counted) -> offset 0x08 reads 4; all other counters read 0.
- Preset offset 0x01 to 0xFFFF_FFFE, drive 3 hssi2egr events -> reads 0xFFFF_FFFF (saturated).
- Write CTRL=0x1 in the same cycle as an egr2edmx[0] event -> offset 0x02 reads 0 and CTRL reads 0.
- FREEZE=1, 10 events on egr2edmx[1], then FREEZE=0 plus 2 events -> offset 0x03 reads 2.
- Read to BASE_ADDR+0x20 -> no readdatavalid; with PTP_BRIDGE_RX_DBG_ERR_CNT_EN, 3 terr packets of 7 -> offset 0x09 reads 3 (0 when the macro is undefined).
